ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch_pkg.sv | 26 ++
 rtl/ifu_fetch_if.sv | 35 +++
 rtl/ifu_fetch_out_buf.sv | 71 +++++++
 rtl/ifu_fetch.sv | 155 +++++++++++++++
 tb/tb_ifu_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the ysyx_23060251 fetch stage.
//   - bus / address width macros
//   - reset PC default and NOP encoding
//   - fetch FSM state encoding
// Optional build macro used by the fetch stage: YSYX_23060251_IFU_MISALIGN_EN.

`ifndef YSYX_23060251_IFU_DEFS
`define YSYX_23060251_IFU_DEFS
`define YSYX_23060251_XLEN     32
`define YSYX_23060251_INST_BUS 32
`endif

package ifu_fetch_pkg;

  localparam int          XLEN_DEF     = `YSYX_23060251_XLEN;
  localparam int          INST_W       = `YSYX_23060251_INST_BUS;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction memory port of the fetch stage.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready. Once valid is raised, the producer holds valid
// and its payload stable until that transfer; ready may toggle freely.
//
//   req_valid  : fetch -> mem, request valid
//   req_ready  : mem -> fetch, request accepted
//   req_addr   : fetch -> mem, word-aligned fetch address
//   resp_valid : mem -> fetch, returned word valid
//   resp_data  : mem -> fetch, returned instruction word
//   resp_ready : fetch -> mem, fetch can accept the response
//
// master: the fetch stage. slave: the instruction memory.

interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic            resp_ready;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ifu_fetch_out_buf.sv
// ifu_fetch_out_buf: 1-entry valid/ready pipeline register carrying {pc, inst}.
//
// Ports:
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   fill_i             : load fill_inst_i/fill_pc_i and raise valid_o
//   squash_i           : drop the held entry (wins over fill and drain)
//   squash_pc_en_i     : on squash, also load pc_o with squash_pc_i
//   ready_i            : consumer accepts the entry this cycle
//   valid_o/inst_o/pc_o: held entry; stable while valid_o && !ready_i
//
// The owner guarantees fill_i is only raised when the entry is empty or is
// being drained; the buffer itself never overwrites a valid entry blindly.

module ifu_fetch_out_buf
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            fill_i,
  input  logic [31:0]     fill_inst_i,
  input  logic [XLEN-1:0] fill_pc_i,
  input  logic            squash_i,
  input  logic            squash_pc_en_i,
  input  logic [XLEN-1:0] squash_pc_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (squash_i) begin
      valid_d = 1'b0;
      if (squash_pc_en_i) begin
        pc_d = squash_pc_i;
      end
    end else if (fill_i) begin
      valid_d = 1'b1;
      inst_d  = fill_inst_i;
      pc_d    = fill_pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      inst_q  <= INST_NOP;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage of the ysyx_23060251 NPC core.
//
// Owns the fetch PC, issues one word fetch at a time on the imem port and
// hands {pc, inst} to decode through a 1-entry output buffer. Redirects from
// execute replace the PC; a fetch already on the bus is completed and its
// response dropped.
//
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   redirect_valid_i/pc_i : execute stage PC change (highest priority)
//   imem                  : ifu_fetch_if master (request/response channels)
//   out_valid_o/ready_i   : decode handshake
//   inst_o, pc_o          : instruction and its PC for decode
//   fetch_misalign_o      : misaligned redirect target held (optional)
//   dbg_state_o           : current fetch FSM state
//
// Build option: YSYX_23060251_IFU_MISALIGN_EN adds fetch_misalign_o. Without
// it, redirect target bits [1:0] are treated as zero.

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  ifu_fetch_if.master     imem,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
`ifdef YSYX_23060251_IFU_MISALIGN_EN
  output logic            fetch_misalign_o,
`endif
  output fetch_state_e    dbg_state_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] redir_pc;
  logic            redir_misalign;
  logic            buf_free;
  logic            fill;
  logic            squash;

`ifdef YSYX_23060251_IFU_MISALIGN_EN
  assign redir_pc       = redirect_pc_i;
  assign redir_misalign = (redirect_pc_i[1:0] != 2'b00);
  assign fetch_misalign_o = misalign_q;
`else
  assign redir_pc       = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
  assign redir_misalign = 1'b0;
`endif

  // Buffer can take a new word by the time a request issued now returns:
  // either it is empty or decode drains it this cycle.
  assign buf_free = !out_valid_o || out_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    misalign_d = misalign_q;
    fill       = 1'b0;
    squash     = 1'b0;

    if (redirect_valid_i) begin
      pc_d       = redir_pc;
      squash     = 1'b1;
      misalign_d = redir_misalign;
    end

    case (state_q)
      IDLE: begin
        // A redirect squashes the buffer, so it frees it as well.
        if (!misalign_d && (buf_free || redirect_valid_i)) begin
          state_d = REQ;
          addr_d  = pc_d;
        end
      end
      REQ: begin
        // addr_q is not touched here: the request stays stable on the bus
        // and its response is marked for dropping instead.
        if (redirect_valid_i) begin
          drop_d = 1'b1;
        end
        if (imem.req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem.resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid_i) begin
            fill = 1'b1;
            pc_d = pc_q + XLEN'(4);
          end
        end else if (redirect_valid_i) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.req_valid  = (state_q == REQ);
  assign imem.req_addr   = addr_q;
  assign imem.resp_ready = (state_q == WAIT);
  assign dbg_state_o     = state_q;

  ifu_fetch_out_buf #(
    .XLEN(XLEN)
  ) u_out_buf (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .fill_i         (fill),
    .fill_inst_i    (imem.resp_data),
    .fill_pc_i      (pc_q),
    .squash_i       (squash),
    .squash_pc_en_i (redirect_valid_i && redir_misalign),
    .squash_pc_i    (redirect_pc_i),
    .ready_i        (out_ready_i),
    .valid_o        (out_valid_o),
    .inst_o         (inst_o),
    .pc_o           (pc_o)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a reactive memory model,
// expected-request and expected-output queues, and a negedge monitor.

module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  fetch_state_e dbg_state;
`ifdef YSYX_23060251_IFU_MISALIGN_EN
  logic        fetch_misalign;
`endif

  ifu_fetch_if #(.XLEN(32)) imem_bus ();

  ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem             (imem_bus),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
`ifdef YSYX_23060251_IFU_MISALIGN_EN
    .fetch_misalign_o (fetch_misalign),
`endif
    .dbg_state_o      (dbg_state)
  );

  // ---------------- memory model ----------------
  // Word returned for address a is ~a; resp_extra adds wait cycles.
  int          resp_extra = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_dly = 0;

  initial begin
    imem_bus.req_ready  = 1'b1;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = '0;
  end

  always @(posedge clk) begin
    logic        hs_req, hs_resp;
    logic [31:0] a;
    hs_req  = imem_bus.req_valid && imem_bus.req_ready;
    hs_resp = imem_bus.resp_valid && imem_bus.resp_ready;
    a       = imem_bus.req_addr;
    #2;
    if (!rst_n) begin
      mem_pend = 1'b0;
    end else begin
      if (hs_resp) mem_pend = 1'b0;
      if (mem_pend && mem_dly > 0) mem_dly--;
      if (hs_req) begin
        mem_pend = 1'b1;
        mem_addr = a;
        mem_dly  = resp_extra;
      end
    end
    imem_bus.resp_valid = mem_pend && (mem_dly == 0);
    imem_bus.resp_data  = ~mem_addr;
  end

  always @(negedge rst_n) begin
    mem_pend = 1'b0;
    imem_bus.resp_valid = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];
  int          xfer_cyc[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, ~pc};
  endfunction

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] ea;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("req_hold_valid", {31'b0, imem_bus.req_valid}, 32'd1);
        chk("req_hold_addr", imem_bus.req_addr, prev_addr);
      end
      if (imem_bus.req_valid && imem_bus.req_ready) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_req", imem_bus.req_addr, 32'hxxxx_xxxx);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", imem_bus.req_addr, ea);
        end
      end
      prev_stall = imem_bus.req_valid && !imem_bus.req_ready;
      prev_addr  = imem_bus.req_addr;
      // A redirect in the same cycle squashes the entry: not a transfer.
      if (out_valid && out_ready && !redirect_valid) begin
        xfer_cyc.push_back(cyc);
        if (exp_out_q.size() == 0) begin
          chk("unexpected_out", pc_o, 32'hxxxx_xxxx);
        end else begin
          e = exp_out_q.pop_front();
          chk("out_pc", pc_o, e[63:32]);
          chk("out_inst", inst_o, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return exp_out_q.size() == 0;
      1: return out_valid;
      2: return imem_bus.resp_ready;
      default: return imem_bus.req_valid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    int n = 0;
    while (!cond(sel) && n < 200) begin
      step();
      n++;
    end
    chk(name, {31'b0, cond(sel)}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_bus.req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_bus.req_addr, RST_PC);
    chk({tag, "_resp_ready"}, {31'b0, imem_bus.resp_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_inst"}, inst_o, INST_NOP);
    chk({tag, "_pc"}, pc_o, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");

    // S1: streaming from reset, decode always ready.
    exp_addr_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    exp_out_q  = '{ent(32'h8000_0000), ent(32'h8000_0004), ent(32'h8000_0008)};
    rst_n = 1'b1;
    wait_for(0, "s1_drain");
    out_ready = 1'b0;
    if (xfer_cyc.size() >= 3) begin
      chk("s1_gap0", xfer_cyc[1] - xfer_cyc[0], 32'd3);
      chk("s1_gap1", xfer_cyc[2] - xfer_cyc[1], 32'd3);
    end else begin
      chk("s1_xfers", xfer_cyc.size(), 32'd3);
    end

    // S2: decode stalls for 5 cycles with 0x8000000C held.
    wait_for(1, "s2_fill");
    for (int i = 0; i < 5; i++) begin
      chk("s2_pc_hold", pc_o, 32'h8000_000C);
      chk("s2_inst_hold", inst_o, 32'h7FFF_FFF3);
      chk("s2_no_req", {31'b0, imem_bus.req_valid}, 32'd0);
      step();
    end

    // S3: redirect in WAIT; stale 0x80000010 word arrives 2 cycles later.
    exp_out_q.push_back(ent(32'h8000_000C));
    exp_out_q.push_back(ent(32'h8000_0100));
    exp_addr_q.push_back(32'h8000_0010);
    exp_addr_q.push_back(32'h8000_0100);
    exp_addr_q.push_back(32'h8000_0104);
    resp_extra = 2;
    out_ready = 1'b1;
    wait_for(2, "s3_wait");
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    resp_extra = 0;
    wait_for(0, "s3_drain");
    out_ready = 1'b0;

    // S4: redirect while REQ is stalled by the memory for 3 cycles.
    wait_for(1, "s4_fill");
    exp_out_q.push_back(ent(32'h8000_0104));
    exp_out_q.push_back(ent(32'h8000_0200));
    exp_addr_q.push_back(32'h8000_0108);
    exp_addr_q.push_back(32'h8000_0200);
    exp_addr_q.push_back(32'h8000_0204);
    imem_bus.req_ready = 1'b0;
    out_ready = 1'b1;
    wait_for(3, "s4_req");
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    for (int i = 0; i < 3; i++) begin
      chk("s4_addr_stable", imem_bus.req_addr, 32'h8000_0108);
      step();
      redirect_valid = 1'b0;
    end
    imem_bus.req_ready = 1'b1;
    wait_for(0, "s4_drain");
    out_ready = 1'b0;

    // S5: redirect in the same cycle decode would take the buffered word.
    wait_for(1, "s5_fill");
    exp_addr_q.push_back(32'h8000_0300);
    exp_addr_q.push_back(32'h8000_0304);
    exp_addr_q.push_back(32'h8000_0308);
    exp_out_q.push_back(ent(32'h8000_0300));
    exp_out_q.push_back(ent(32'h8000_0304));
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    chk("s5_squash", {31'b0, out_valid}, 32'd0);
    chk("s5_req_addr", imem_bus.req_addr, 32'h8000_0300);
    wait_for(0, "s5_drain");
    out_ready = 1'b0;

    // S6: reset asserted while waiting for a response.
    wait_for(1, "s6_fill");
    exp_out_q.push_back(ent(32'h8000_0308));
    exp_addr_q.push_back(32'h8000_030C);
    resp_extra = 3;
    out_ready = 1'b1;
    wait_for(2, "s6_wait");
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("s6_rst");
    resp_extra = 0;
    step();
    step();
    exp_addr_q.push_back(32'h8000_0000);
    exp_addr_q.push_back(32'h8000_0004);
    exp_out_q.push_back(ent(32'h8000_0000));
    rst_n = 1'b1;
    wait_for(0, "s6_drain");
    out_ready = 1'b0;

`ifdef YSYX_23060251_IFU_MISALIGN_EN
    // S7: misaligned redirect holds the fetch; an aligned one resumes it.
    wait_for(1, "s7_fill");
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s7_misalign", {31'b0, fetch_misalign}, 32'd1);
      chk("s7_pc", pc_o, 32'h8000_0102);
      chk("s7_no_req", {31'b0, imem_bus.req_valid}, 32'd0);
      chk("s7_out_valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    exp_addr_q.push_back(32'h8000_0400);
    exp_addr_q.push_back(32'h8000_0404);
    exp_out_q.push_back(ent(32'h8000_0400));
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0400;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("s7_misalign_clr", {31'b0, fetch_misalign}, 32'd0);
    wait_for(0, "s7_drain");
    out_ready = 1'b0;
`endif

    repeat (12) step();
    chk("end_addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("end_out_q_empty", exp_out_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
